// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: PC geometry and FSM encoding.
package prefetch_pkg;

    localparam int unsigned PC_BITS     = 16;
    localparam int unsigned DEF_NSHIFT  = 2;
    localparam int unsigned PC_DIGITS   = PC_BITS / DEF_NSHIFT;
    localparam int unsigned PC_IDX_BITS = $clog2(PC_BITS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_INST  = 3'd1,
        ST_WAIT_INST = 3'd2,
        ST_REQ_IMM   = 3'd3,
        ST_WAIT_IMM  = 3'd4
    } pf_state_e;

    // Width of a digit index for a given serial step size (at least one bit).
    function automatic int unsigned digit_idx_bits(input int unsigned nshift);
        int unsigned digits;
        digits = PC_BITS / nshift;
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_pc_reg.sv
// Program counter with digit-serial read/write access and increment (write beats increment).
module serial_pc_reg
    import prefetch_pkg::*;
#(
    parameter int unsigned        NSHIFT   = 2,
    parameter logic [PC_BITS-1:0] RESET_PC = 16'h0000,
    localparam int unsigned       CW       = digit_idx_bits(NSHIFT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [CW-1:0]      wr_idx,
    input  logic [NSHIFT-1:0]  wr_data,
    input  logic               inc,
    input  logic [CW-1:0]      rd_idx,
    output logic [NSHIFT-1:0]  rd_data,
    output logic [PC_BITS-1:0] pc
);

    logic [PC_BITS-1:0]     pc_q;
    logic [PC_BITS-1:0]     pc_d;
    logic [PC_IDX_BITS-1:0] wr_base;
    logic [PC_IDX_BITS-1:0] rd_base;

    assign wr_base = PC_IDX_BITS'(32'(wr_idx) * NSHIFT);
    assign rd_base = PC_IDX_BITS'(32'(rd_idx) * NSHIFT);

    always_comb begin
        pc_d = pc_q;
        if (wr_en) begin
            pc_d[wr_base +: NSHIFT] = wr_data;
        end else if (inc) begin
            pc_d = pc_q + PC_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign rd_data = pc_q[rd_base +: NSHIFT];
    assign pc      = pc_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: fetches instruction words and immediates over a
// valid/ready channel and exposes the PC and immediate digit-serially.
module inst_prefetch
    import prefetch_pkg::*;
#(
    parameter int unsigned        NSHIFT   = 2,
    parameter logic [PC_BITS-1:0] RESET_PC = 16'h0000,
    localparam int unsigned       CW       = digit_idx_bits(NSHIFT)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               inst_valid,
    output logic [15:0]        inst,
    input  logic               inst_done,
    output logic [15:0]        imm_full,
    input  logic               load_imm16,
    output logic               imm16_loaded,
    output logic [NSHIFT-1:0]  imm_data_in,
    input  logic               next_imm_data,
    input  logic               block_prefetch,
    input  logic               write_pc,
    input  logic               ext_pc_next,
    input  logic [CW-1:0]      comp_counter,
    output logic               prefetch_idle,
    input  logic [NSHIFT-1:0]  pc_data_out,
    output logic [NSHIFT-1:0]  pc_data_in,
    output logic               fetch_valid,
    output logic [15:0]        fetch_addr,
    input  logic               fetch_ready,
    input  logic               fetch_data_valid,
    input  logic [15:0]        fetch_data
);

    pf_state_e          state_q, state_d;
    logic               inst_valid_q, inst_valid_d;
    logic [15:0]        inst_q, inst_d;
    logic [15:0]        imm_q, imm_d;
    logic               imm_loaded_q, imm_loaded_d;
    logic               fetch_accept;
    logic               idle;
    logic [PC_BITS-1:0] pc;

    assign idle = (state_q == ST_IDLE);

    // Decoder-side PC access is only honoured while no fetch is in flight.
    serial_pc_reg #(
        .NSHIFT   (NSHIFT),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (write_pc && idle),
        .wr_idx  (comp_counter),
        .wr_data (pc_data_out),
        .inc     (fetch_accept || (ext_pc_next && idle)),
        .rd_idx  (comp_counter),
        .rd_data (pc_data_in),
        .pc      (pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q && !inst_done;
        inst_d       = inst_q;
        imm_d        = next_imm_data ? (imm_q >> NSHIFT) : imm_q;
        imm_loaded_d = 1'b0;
        fetch_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Use the post-retire view of inst_valid so a refetch starts right after inst_done.
                if (load_imm16) begin
                    state_d = ST_REQ_IMM;
                end else if ((!inst_valid_q || inst_done) && !block_prefetch) begin
                    state_d = ST_REQ_INST;
                end
            end
            ST_REQ_INST: begin
                if (fetch_ready) begin
                    fetch_accept = 1'b1;
                    state_d      = ST_WAIT_INST;
                end
            end
            ST_WAIT_INST: begin
                if (fetch_data_valid) begin
                    inst_d       = fetch_data;
                    inst_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_REQ_IMM: begin
                if (fetch_ready) begin
                    fetch_accept = 1'b1;
                    state_d      = ST_WAIT_IMM;
                end
            end
            ST_WAIT_IMM: begin
                if (fetch_data_valid) begin
                    imm_d        = fetch_data;
                    imm_loaded_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= 16'h0000;
            imm_q        <= 16'h0000;
            imm_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            imm_q        <= imm_d;
            imm_loaded_q <= imm_loaded_d;
        end
    end

    assign inst_valid    = inst_valid_q;
    assign inst          = inst_q;
    assign imm_full      = imm_q;
    assign imm16_loaded  = imm_loaded_q;
    assign imm_data_in   = imm_q[NSHIFT-1:0];
    assign prefetch_idle = idle;
    assign fetch_valid   = (state_q == ST_REQ_INST) || (state_q == ST_REQ_IMM);
    assign fetch_addr    = pc;

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch against a transaction-level PC/inst/imm model.
module tb_inst_prefetch;

    localparam int unsigned NSHIFT = 2;
    localparam int unsigned NDIG   = 16 / NSHIFT;
    localparam logic [15:0] RPC    = 16'h0100;

    logic              clk;
    logic              reset;
    logic              inst_valid;
    logic [15:0]       inst;
    logic              inst_done;
    logic [15:0]       imm_full;
    logic              load_imm16;
    logic              imm16_loaded;
    logic [NSHIFT-1:0] imm_data_in;
    logic              next_imm_data;
    logic              block_prefetch;
    logic              write_pc;
    logic              ext_pc_next;
    logic [2:0]        comp_counter;
    logic              prefetch_idle;
    logic [NSHIFT-1:0] pc_data_out;
    logic [NSHIFT-1:0] pc_data_in;
    logic              fetch_valid;
    logic [15:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_data_valid;
    logic [15:0]       fetch_data;

    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_inst;
    logic [15:0] m_imm;

    inst_prefetch #(.NSHIFT(NSHIFT), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst(inst), .inst_done(inst_done),
        .imm_full(imm_full), .load_imm16(load_imm16), .imm16_loaded(imm16_loaded),
        .imm_data_in(imm_data_in), .next_imm_data(next_imm_data),
        .block_prefetch(block_prefetch), .write_pc(write_pc), .ext_pc_next(ext_pc_next),
        .comp_counter(comp_counter), .prefetch_idle(prefetch_idle),
        .pc_data_out(pc_data_out), .pc_data_in(pc_data_in),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NSHIFT-1:0] digit_of(input logic [15:0] v, input int d);
        return NSHIFT'(v >> (d * NSHIFT));
    endfunction

    function automatic logic [15:0] set_digit(input logic [15:0] v, input int d, input int x);
        int unsigned mask;
        mask = ((1 << NSHIFT) - 1) << (d * NSHIFT);
        return 16'((32'(v) & ~mask) | ((x << (d * NSHIFT)) & mask));
    endfunction

    // Memory side of one transaction; the model PC advances on acceptance.
    task automatic serve(input bit is_imm, input int rdly, input int ddly);
        int          n;
        logic [15:0] a;
        logic [15:0] exp_addr;
        n = 0;
        while (!fetch_valid && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL serve_timeout: fetch_valid=%0b required 1", fetch_valid);
            return;
        end
        repeat (rdly) tick;
        a = fetch_addr;
        exp_addr = m_pc;
        fetch_ready = 1'b1;
        tick;
        fetch_ready = 1'b0;
        m_pc = m_pc + 16'd1;
        repeat (ddly) tick;
        fetch_data       = mem[a];
        fetch_data_valid = 1'b1;
        tick;
        fetch_data_valid = 1'b0;
        fetch_data       = 16'($urandom);
        if (is_imm) m_imm = mem[exp_addr];
        else        m_inst = mem[exp_addr];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        m_pc = RPC; m_imm = 16'h0000;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %0b want 0", inst_valid); end
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL rst_inst: got %h want 0000", inst); end
        checks++; if (imm_full !== 16'h0000) begin errors++; $display("FAIL rst_imm_full: got %h want 0000", imm_full); end
        checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL rst_imm16_loaded: got %0b want 0", imm16_loaded); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid: got %0b want 0", fetch_valid); end
        checks++; if (prefetch_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %0b want 1", prefetch_idle); end
        for (int d = 0; d < int'(NDIG); d++) begin
            comp_counter = 3'(d);
            #1;
            checks++;
            if (pc_data_in !== digit_of(m_pc, d)) begin
                errors++; $display("FAIL rst_pc_digit%0d: got %0d want %0d", d, pc_data_in, digit_of(m_pc, d));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        tick;
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL first_fetch: valid=%0b addr=%h want 1 %h", fetch_valid, fetch_addr, m_pc);
        end
        serve(1'b0, 0, 0);
        checks++; if (inst !== m_inst || inst_valid !== 1'b1) begin
            errors++; $display("FAIL first_inst: inst=%h valid=%0b want %h 1", inst, inst_valid, m_inst);
        end
        checks++; if (fetch_addr !== m_pc || prefetch_idle !== 1'b1) begin
            errors++; $display("FAIL first_pc: pc=%h idle=%0b want %h 1", fetch_addr, prefetch_idle, m_pc);
        end
    endtask

    task automatic test_block;
        logic [15:0] held;
        held = m_inst;
        block_prefetch = 1'b1;
        inst_done = 1'b1;
        tick;
        inst_done = 1'b0;
        checks++; if (inst_valid !== 1'b0 || inst !== held) begin
            errors++; $display("FAIL retire: valid=%0b inst=%h want 0 %h", inst_valid, inst, held);
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL blocked_cycle%0d: fetch_valid=%0b want 0", i, fetch_valid); end
            tick;
        end
        block_prefetch = 1'b0;
        tick;
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL unblock_fetch: valid=%0b addr=%h want 1 %h", fetch_valid, fetch_addr, m_pc);
        end
        serve(1'b0, 0, 1);
        checks++; if (inst !== m_inst || inst_valid !== 1'b1) begin
            errors++; $display("FAIL unblock_inst: inst=%h valid=%0b want %h 1", inst, inst_valid, m_inst);
        end
    endtask

    task automatic test_imm;
        mem[m_pc] = 16'hBEEF;
        load_imm16 = 1'b1;
        tick;
        load_imm16 = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL imm_req: valid=%0b addr=%h want 1 %h", fetch_valid, fetch_addr, m_pc);
        end
        fetch_ready = 1'b1;
        tick;
        fetch_ready = 1'b0;
        fetch_data = mem[fetch_addr - 16'd1];
        fetch_data_valid = 1'b1;
        tick;
        fetch_data_valid = 1'b0;
        m_imm = mem[m_pc];
        m_pc = m_pc + 16'd1;
        checks++; if (imm16_loaded !== 1'b1 || imm_full !== m_imm) begin
            errors++; $display("FAIL imm_latency3: loaded=%0b imm=%h want 1 %h", imm16_loaded, imm_full, m_imm);
        end
        tick;
        checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL imm_pulse: loaded=%0b want 0", imm16_loaded); end
        for (int i = 0; i < int'(NDIG); i++) begin
            checks++; if (imm_data_in !== digit_of(m_imm, 0)) begin
                errors++; $display("FAIL imm_digit%0d: got %0d want %0d", i, imm_data_in, digit_of(m_imm, 0));
            end
            next_imm_data = 1'b1;
            tick;
            next_imm_data = 1'b0;
            m_imm = m_imm / 16'(1 << NSHIFT);
        end
        checks++; if (imm_full !== 16'h0000) begin errors++; $display("FAIL imm_drained: got %h want 0000", imm_full); end
    endtask

    task automatic write_all(input int vals [8], input bit randomize_vals);
        int v;
        for (int d = 0; d < int'(NDIG); d++) begin
            v = randomize_vals ? int'($urandom_range(0, (1 << NSHIFT) - 1)) : vals[d];
            comp_counter = 3'(d);
            pc_data_out  = NSHIFT'(v);
            write_pc     = 1'b1;
            ext_pc_next  = 1'($urandom_range(0, 1));
            tick;
            write_pc     = 1'b0;
            ext_pc_next  = 1'b0;
            m_pc = set_digit(m_pc, d, v);
            checks++; if (pc_data_in !== NSHIFT'(v)) begin
                errors++; $display("FAIL pc_readback%0d: got %0d want %0d", d, pc_data_in, v);
            end
        end
        checks++; if (fetch_addr !== m_pc) begin errors++; $display("FAIL pc_after_write: got %h want %h", fetch_addr, m_pc); end
    endtask

    task automatic test_write_pc;
        int spec_v [8] = '{0, 0, 2, 1, 0, 0, 0, 0};
        int ones  [8]  = '{3, 3, 3, 3, 3, 3, 3, 3};
        int k;
        write_all(spec_v, 1'b0);
        k = int'($urandom_range(1, 5));
        ext_pc_next = 1'b1;
        repeat (k) tick;
        ext_pc_next = 1'b0;
        m_pc = m_pc + 16'(k);
        checks++; if (fetch_addr !== m_pc) begin errors++; $display("FAIL ext_inc: got %h want %h", fetch_addr, m_pc); end
        write_all(ones, 1'b0);
        ext_pc_next = 1'b1;
        tick;
        ext_pc_next = 1'b0;
        m_pc = m_pc + 16'd1;
        checks++; if (fetch_addr !== m_pc || m_pc !== 16'h0000) begin
            errors++; $display("FAIL pc_wrap: got %h want %h", fetch_addr, m_pc);
        end
        write_all(spec_v, 1'b1);
        inst_done = 1'b1;
        tick;
        inst_done = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL fetch_after_write: valid=%0b addr=%h want 1 %h", fetch_valid, fetch_addr, m_pc);
        end
        serve(1'b0, 1, 0);
        checks++; if (inst !== m_inst) begin errors++; $display("FAIL inst_after_write: got %h want %h", inst, m_inst); end
    endtask

    task automatic test_stall;
        inst_done = 1'b1;
        tick;
        inst_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
                errors++; $display("FAIL stall%0d: valid=%0b addr=%h want 1 %h", i, fetch_valid, fetch_addr, m_pc);
            end
            write_pc     = 1'b1;
            comp_counter = 3'($urandom_range(0, NDIG - 1));
            pc_data_out  = NSHIFT'($urandom);
            ext_pc_next  = 1'b1;
            tick;
        end
        write_pc = 1'b0;
        ext_pc_next = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL stall_end: valid=%0b addr=%h want 1 %h", fetch_valid, fetch_addr, m_pc);
        end
        serve(1'b0, 0, int'($urandom_range(0, 3)));
        checks++; if (inst !== m_inst || fetch_addr !== m_pc) begin
            errors++; $display("FAIL stall_done: inst=%h pc=%h want %h %h", inst, fetch_addr, m_inst, m_pc);
        end
    endtask

    task automatic test_reset_mid;
        inst_done = 1'b1;
        tick;
        inst_done = 1'b0;
        fetch_ready = 1'b1;
        tick;
        fetch_ready = 1'b0;
        checks++; if (prefetch_idle !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL in_wait: idle=%0b valid=%0b want 0 0", prefetch_idle, fetch_valid);
        end
        reset = 1'b1;
        tick;
        m_pc = RPC; m_imm = 16'h0000;
        checks++; if (prefetch_idle !== 1'b1 || inst_valid !== 1'b0 || fetch_addr !== RPC) begin
            errors++; $display("FAIL mid_reset: idle=%0b valid=%0b pc=%h want 1 0 %h", prefetch_idle, inst_valid, fetch_addr, RPC);
        end
        fetch_data = 16'hDEAD;
        fetch_data_valid = 1'b1;
        reset = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b0 || fetch_valid !== 1'b1 || fetch_addr !== RPC) begin
            errors++; $display("FAIL late_data: valid=%0b fv=%0b addr=%h want 0 1 %h", inst_valid, fetch_valid, fetch_addr, RPC);
        end
        tick;
        fetch_data_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL late_data2: valid=%0b want 0", inst_valid); end
        serve(1'b0, 0, 0);
        checks++; if (inst !== m_inst || inst_valid !== 1'b1 || fetch_addr !== m_pc) begin
            errors++; $display("FAIL refetch: inst=%h v=%0b pc=%h want %h 1 %h", inst, inst_valid, fetch_addr, m_inst, m_pc);
        end
    endtask

    task automatic test_random;
        int op;
        int k;
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                inst_done = 1'b1;
                tick;
                inst_done = 1'b0;
                checks++; if (fetch_addr !== m_pc) begin errors++; $display("FAIL rnd_inst_addr%0d: got %h want %h", it, fetch_addr, m_pc); end
                serve(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                checks++; if (inst !== m_inst || inst_valid !== 1'b1) begin
                    errors++; $display("FAIL rnd_inst%0d: inst=%h v=%0b want %h 1", it, inst, inst_valid, m_inst);
                end
            end else if (op == 1) begin
                mem[m_pc] = 16'($urandom);
                next_imm_data = 1'($urandom_range(0, 1));
                load_imm16 = 1'b1;
                tick;
                load_imm16 = 1'b0;
                checks++; if (fetch_addr !== m_pc) begin errors++; $display("FAIL rnd_imm_addr%0d: got %h want %h", it, fetch_addr, m_pc); end
                serve(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                checks++; if (imm16_loaded !== 1'b1 || imm_full !== m_imm) begin
                    errors++; $display("FAIL rnd_imm%0d: loaded=%0b imm=%h want 1 %h", it, imm16_loaded, imm_full, m_imm);
                end
                if (next_imm_data) m_imm = m_imm / 16'(1 << NSHIFT);
                tick;
                next_imm_data = 1'b0;
                k = int'($urandom_range(0, NDIG));
                for (int s = 0; s < k; s++) begin
                    checks++; if (imm_data_in !== digit_of(m_imm, 0)) begin
                        errors++; $display("FAIL rnd_shift%0d_%0d: got %0d want %0d", it, s, imm_data_in, digit_of(m_imm, 0));
                    end
                    next_imm_data = 1'b1;
                    tick;
                    next_imm_data = 1'b0;
                    m_imm = m_imm / 16'(1 << NSHIFT);
                end
            end else begin
                k = int'($urandom_range(1, 3));
                ext_pc_next = 1'b1;
                repeat (k) tick;
                ext_pc_next = 1'b0;
                m_pc = m_pc + 16'(k);
                checks++; if (fetch_addr !== m_pc) begin errors++; $display("FAIL rnd_pc%0d: got %h want %h", it, fetch_addr, m_pc); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; inst_done = 1'b0; load_imm16 = 1'b0; next_imm_data = 1'b0;
        block_prefetch = 1'b0; write_pc = 1'b0; ext_pc_next = 1'b0; comp_counter = 3'd0;
        pc_data_out = '0; fetch_ready = 1'b0; fetch_data_valid = 1'b0; fetch_data = 16'h0000;
        m_pc = RPC; m_inst = 16'h0000; m_imm = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[RPC] = 16'h2345;
        test_reset;
        test_block;
        test_imm;
        test_write_pc;
        test_stall;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
